data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_if.sv | 20 ++
 rtl/data_memory_responder.sv | 83 ++++++++
 tb/tb_data_memory_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: memory-stage request/response bus between the pipeline and the data memory.
interface data_memory_responder_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        dataValid;
    logic        addrError;
    logic [7:0]  errorCount;
    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, stall, dataValid, addrError, errorCount
    );
    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, stall, dataValid, addrError, errorCount
    );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory with fixed access latency, stall generation and request rejection.
module data_memory_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic                     clk,
    input logic                     reset,
    data_memory_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_write_q, op_write_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    read_data_q, read_data_d;
    logic           data_valid_q, data_valid_d;
    logic           addr_error_q, addr_error_d;
    logic [7:0]     error_count_q, error_count_d;
    logic [31:0]    mem [DEPTH];
    logic           legal, accept, reject, commit, commit_we;
    logic [AW-1:0]  commit_idx;
    logic [31:0]    commit_data;
    assign legal  = (bus.memRead ^ bus.memWrite) && (bus.address[1:0] == 2'b00)
                    && (bus.address[31:AW+2] == '0);
    assign accept = (state_q == IDLE) && legal;
    assign reject = (state_q == IDLE) && (bus.memRead || bus.memWrite) && !legal;
    // With LATENCY==1 the access completes at the accepting edge, straight from the bus.
    assign commit      = ((state_q == BUSY) && (cnt_q == 4'd1)) || (accept && LATENCY == 1);
    assign commit_we   = (state_q == IDLE) ? bus.memWrite : op_write_q;
    assign commit_idx  = (state_q == IDLE) ? bus.address[AW+1:2] : idx_q;
    assign commit_data = (state_q == IDLE) ? bus.writeData : wdata_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_write_q    <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
            read_data_q   <= '0;
            data_valid_q  <= 1'b0;
            addr_error_q  <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_write_q    <= op_write_d;
            idx_q         <= idx_d;
            wdata_q       <= wdata_d;
            read_data_q   <= read_data_d;
            data_valid_q  <= data_valid_d;
            addr_error_q  <= addr_error_d;
            error_count_q <= error_count_d;
        end
    end
    // Array is never cleared, and a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (reset && commit && commit_we) mem[commit_idx] <= commit_data;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? ((LATENCY == 1) ? DONE : BUSY) : IDLE)
                : (state_q == BUSY) ? ((cnt_q == 4'd1) ? DONE : BUSY)
                : IDLE;
    end
    always_comb begin
        cnt_d         = accept ? 4'(LATENCY - 1) : (state_q == BUSY) ? cnt_q - 4'd1 : cnt_q;
        op_write_d    = accept ? bus.memWrite : op_write_q;
        idx_d         = accept ? bus.address[AW+1:2] : idx_q;
        wdata_d       = accept ? bus.writeData : wdata_q;
        read_data_d   = (commit && !commit_we) ? mem[commit_idx] : read_data_q;
        data_valid_d  = commit;
        addr_error_d  = reject;
        error_count_d = (reject && error_count_q != 8'hFF) ? error_count_q + 8'd1 : error_count_q;
    end
    always_comb begin
        bus.stall      = accept || (state_q == BUSY);
        bus.readData   = read_data_q;
        bus.dataValid  = data_valid_q;
        bus.addrError  = addr_error_q;
        bus.errorCount = error_count_q;
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vectors against LATENCY=2, 3 and 1 instances sharing one stimulus bus.
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    int          checks = 0, failures = 0;
    always #5 clk = ~clk;
    data_memory_responder_if ia ();
    data_memory_responder_if ib ();
    data_memory_responder_if ic ();
    assign ia.memRead = rd;  assign ia.memWrite = wr;  assign ia.address = addr;  assign ia.writeData = wdata;
    assign ib.memRead = rd;  assign ib.memWrite = wr;  assign ib.address = addr;  assign ib.writeData = wdata;
    assign ic.memRead = rd;  assign ic.memWrite = wr;  assign ic.address = addr;  assign ic.writeData = wdata;
    data_memory_responder #(.LATENCY(2)) dut_a (.clk(clk), .reset(rst_n), .bus(ia));
    data_memory_responder #(.LATENCY(3)) dut_b (.clk(clk), .reset(rst_n), .bus(ib));
    data_memory_responder #(.LATENCY(1)) dut_c (.clk(clk), .reset(rst_n), .bus(ic));
    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic        stall, dv, err;
        logic [31:0] rdata;
        logic [7:0]  cnt;
    } vec_t;
    vec_t vt [27];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        8'd0};
        vt[1]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        8'd0};
        vt[2]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        8'd0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        8'd0};
        vt[4]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'd0};
        vt[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'd0};
        vt[6]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[8]  = '{1'b0, 1'b1, 32'h0,   32'h11111111, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[11] = '{1'b1, 1'b0, 32'h13,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
        vt[12] = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'd1};
        vt[13] = '{1'b1, 1'b1, 32'h0,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'd2};
        vt[14] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'd3};
        vt[15] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd3};
        vt[16] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd3};
        vt[17] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h11111111, 8'd3};
        vt[18] = '{1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h11111111, 8'd3};
        vt[19] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h11111111, 8'd3};
        vt[20] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h11111111, 8'd3};
        vt[21] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11111111, 8'd3};
        vt[22] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h11111111, 8'd3};
        vt[23] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 8'd3};
        vt[24] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 8'd3};
        vt[25] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 8'd3};
        vt[26] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'd3};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("a_reset_stall", ia.stall, 0);
        chk("a_reset_dv", ia.dataValid, 0);
        chk("a_reset_err", ia.addrError, 0);
        chk("a_reset_rdata", ia.readData, 0);
        chk("a_reset_cnt", ia.errorCount, 0);
        for (int i = 0; i < 27; i++) begin
            step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
            chk($sformatf("a_stall[%0d]", i), ia.stall, vt[i].stall);
            chk($sformatf("a_dv[%0d]", i), ia.dataValid, vt[i].dv);
            chk($sformatf("a_err[%0d]", i), ia.addrError, vt[i].err);
            chk($sformatf("a_rdata[%0d]", i), ia.readData, vt[i].rdata);
            chk($sformatf("a_cnt[%0d]", i), ia.errorCount, 32'(vt[i].cnt));
        end
        do_reset();
        step(0, 1, 32'h20, 32'hAAAA0000);  chk("b_stall_t0", ib.stall, 1);
        step(0, 0, 0, 0);                  chk("b_stall_t1", ib.stall, 1);
        step(0, 0, 0, 0);                  chk("b_stall_t2", ib.stall, 1);
        chk("b_dv_t2", ib.dataValid, 0);
        step(0, 0, 0, 0);                  chk("b_stall_t3", ib.stall, 0);
        chk("b_dv_t3", ib.dataValid, 1);
        step(1, 0, 32'h20, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("b_rdata_first", ib.readData, 32'hAAAA0000);
        step(1, 0, 32'h1, 0);              chk("b_rej_stall", ib.stall, 0);
        step(0, 0, 0, 0);                  chk("b_rej_cnt", ib.errorCount, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        rst_n = 1'b1; wr = 1'b0; addr = 0; wdata = 0;
        @(negedge clk);
        chk("b_rst_stall", ib.stall, 0);
        chk("b_rst_dv", ib.dataValid, 0);
        chk("b_rst_err", ib.addrError, 0);
        chk("b_rst_rdata", ib.readData, 0);
        chk("b_rst_cnt", ib.errorCount, 0);
        step(0, 1, 32'h20, 32'h12345678);  chk("b_abort_stall_t0", ib.stall, 1);
        @(posedge clk);
        #1;
        wr = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("b_abort_stall", ib.stall, 0);
        step(0, 0, 0, 0);                  chk("b_abort_dv", ib.dataValid, 0);
        step(1, 0, 32'h20, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("b_word8_kept_dv", ib.dataValid, 1);
        chk("b_word8_kept", ib.readData, 32'hAAAA0000);
        do_reset();
        step(0, 1, 32'h0, 32'hA5A5A5A5);   chk("c_wr_stall", ic.stall, 1);
        step(0, 1, 32'h0, 32'hA5A5A5A5);   chk("c_wr_done_stall", ic.stall, 0);
        chk("c_wr_dv", ic.dataValid, 1);
        step(1, 0, 32'h0, 0);              chk("c_rd_stall", ic.stall, 1);
        chk("c_rd_dv_t0", ic.dataValid, 0);
        step(0, 0, 0, 0);                  chk("c_rd_done_stall", ic.stall, 0);
        chk("c_rd_dv", ic.dataValid, 1);
        chk("c_rdata", ic.readData, 32'hA5A5A5A5);
        for (int i = 1; i <= 256; i++) begin
            step(1, 0, 32'h2, 0);
            if (i == 255) chk("c_cnt_254", ic.errorCount, 254);
            if (i == 256) chk("c_cnt_255", ic.errorCount, 255);
        end
        step(0, 0, 0, 0);
        chk("c_cnt_sat", ic.errorCount, 255);
        chk("c_err_pulse", ic.addrError, 1);
        chk("c_rdata_hold", ic.readData, 32'hA5A5A5A5);
        step(0, 0, 0, 0);
        chk("c_err_clear", ic.addrError, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
